// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  typedef enum logic [4:0] {
    ExcInt  = 5'd0,
    ExcAdEL = 5'd4,
    ExcAdES = 5'd5,
    ExcSys  = 5'd8,
    ExcBp   = 5'd9,
    ExcRI   = 5'd10,
    ExcOv   = 5'd12
  } exc_code_e;

  // Field order matches the mem_exc bus, MSB first.
  typedef struct packed {
    logic ades;
    logic adel_d;
    logic bp;
    logic sys;
    logic ov;
    logic ri;
    logic adel_f;
  } exc_flags_t;

  typedef struct packed {
    logic        we;
    logic        bd;
    logic        exl;
    logic [4:0]  exc;
    logic [31:0] epc;
    logic [31:0] bva;
  } reg_error;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DRAIN  = 2'd2
  } exc_state_e;

endpackage

// File: rtl/intr_sync.sv
// Per-bit flop-chain synchroniser; every stage clears on synchronous reset.
module intr_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer driving CP0: arbitration, CP0 write, flush and PC redirect.
// Optional Count/Compare timer on hard_intr[5] enabled by defining EXC_TIMER_EN.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int_raw,
  output logic [5:0]  hard_intr,
  input  logic [7:0]  intr_vect,
  input  logic [31:0] er_epc,
  input  logic        cur_bd,
  input  logic [4:0]  cur_exc,
  input  logic [31:0] cur_bva,
  input  logic        stall,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [6:0]  mem_exc,
  input  logic [31:0] mem_badva,
  input  logic        mem_eret,
  output reg_error    cp0w,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        tmr_we,
  input  logic [31:0] tmr_cmp
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  exc_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  reg_error        cp0w_q, cp0w_d;
  logic            redir_valid_q, redir_valid_d;
  logic [31:0]     redir_pc_q, redir_pc_d;

  exc_flags_t flags;
  logic       accept;
  logic       is_exc;
  exc_code_e  code;
  logic [31:0] bva;

  assign flags  = exc_flags_t'(mem_exc);
  assign accept = (state_q == IDLE) && mem_valid && !stall &&
                  ((intr_vect != '0) || (mem_exc != '0) || mem_eret);
  assign is_exc = (intr_vect != '0) || (mem_exc != '0);

  // Fixed-priority pick; interrupts first, ERET only when nothing else is flagged.
  always_comb begin
    code = ExcInt;
    bva  = cur_bva;
    if (intr_vect != '0) begin
      code = ExcInt;
    end else if (flags.adel_f) begin
      code = ExcAdEL;
      bva  = mem_pc;
    end else if (flags.ri) begin
      code = ExcRI;
    end else if (flags.ov) begin
      code = ExcOv;
    end else if (flags.sys) begin
      code = ExcSys;
    end else if (flags.bp) begin
      code = ExcBp;
    end else if (flags.adel_d) begin
      code = ExcAdEL;
      bva  = mem_badva;
    end else if (flags.ades) begin
      code = ExcAdES;
      bva  = mem_badva;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cp0w_d        = '0;
    redir_valid_d = 1'b0;
    redir_pc_d    = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = COMMIT;
          cp0w_d.we     = 1'b1;
          redir_valid_d = 1'b1;
          if (is_exc) begin
            cp0w_d.bd  = mem_bd;
            cp0w_d.exl = 1'b1;
            cp0w_d.exc = code;
            cp0w_d.epc = mem_bd ? (mem_pc - 32'd4) : mem_pc;
            cp0w_d.bva = bva;
            redir_pc_d = EXC_VECTOR;
          end else begin
            cp0w_d.bd  = cur_bd;
            cp0w_d.exl = 1'b0;
            cp0w_d.exc = cur_exc;
            cp0w_d.epc = er_epc;
            cp0w_d.bva = cur_bva;
            redir_pc_d = er_epc;
          end
        end
      end
      COMMIT: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = DRAIN;
          cnt_d   = CntW'(FLUSH_CYCLES - 2);
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cp0w_q        <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cp0w_q        <= cp0w_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign cp0w        = cp0w_q;
  assign flush       = (state_q != IDLE);
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;

  logic [5:0] synced;

  intr_sync #(
    .STAGES(SYNC_STAGES),
    .WIDTH (6)
  ) u_intr_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (hw_int_raw),
    .synced(synced)
  );

`ifdef EXC_TIMER_EN
  logic [31:0] count_q, cmp_q;
  logic        tick_q, pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'h0;
      // All-ones so the timer stays quiet until software programs Compare.
      cmp_q   <= 32'hFFFF_FFFF;
      tick_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
      if (tick_q) count_q <= count_q + 32'd1;
      if (tmr_we) begin
        cmp_q  <= tmr_cmp;
        pend_q <= 1'b0;
      end else if (count_q == cmp_q) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign hard_intr = {synced[5] | pend_q, synced[4:0]};
`else
  logic unused_tmr;
  assign unused_tmr = ^{tmr_we, tmr_cmp};
  assign hard_intr  = synced;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl (FLUSH_CYCLES=3, SYNC_STAGES=2); timer checks need EXC_TIMER_EN.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int_raw;
  logic [5:0]  hard_intr;
  logic [7:0]  intr_vect;
  logic [31:0] er_epc;
  logic        cur_bd;
  logic [4:0]  cur_exc;
  logic [31:0] cur_bva;
  logic        stall;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [6:0]  mem_exc;
  logic [31:0] mem_badva;
  logic        mem_eret;
  reg_error    cp0w;
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        tmr_we;
  logic [31:0] tmr_cmp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exc_ctrl #(
    .EXC_VECTOR  (32'hBFC0_0380),
    .SYNC_STAGES (2),
    .FLUSH_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hw_int_raw (hw_int_raw),
    .hard_intr  (hard_intr),
    .intr_vect  (intr_vect),
    .er_epc     (er_epc),
    .cur_bd     (cur_bd),
    .cur_exc    (cur_exc),
    .cur_bva    (cur_bva),
    .stall      (stall),
    .mem_valid  (mem_valid),
    .mem_pc     (mem_pc),
    .mem_bd     (mem_bd),
    .mem_exc    (mem_exc),
    .mem_badva  (mem_badva),
    .mem_eret   (mem_eret),
    .cp0w       (cp0w),
    .flush      (flush),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .tmr_we     (tmr_we),
    .tmr_cmp    (tmr_cmp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_valid = 1'b0;
    mem_exc   = 7'b0;
    mem_eret  = 1'b0;
    intr_vect = 8'h0;
    stall     = 1'b0;
  endtask

  task automatic present(input logic [6:0] exc, input logic [31:0] pc, input logic bd);
    mem_valid = 1'b1;
    mem_exc   = exc;
    mem_pc    = pc;
    mem_bd    = bd;
  endtask

  // Remaining two DRAIN cycles after the cycle following commit.
  task automatic drain();
    step();
    step();
    step();
  endtask

  int first_hi;

  initial begin
    rst = 1'b1;
    hw_int_raw = 6'h0;
    er_epc = 32'h0; cur_bd = 1'b0; cur_exc = 5'd0; cur_bva = 32'hCAFE_0000;
    mem_pc = 32'h0; mem_bd = 1'b0; mem_badva = 32'h0;
    tmr_we = 1'b0; tmr_cmp = 32'h0;
    clear_in();
    repeat (3) step();
    check("rst_cp0w", 64'(cp0w), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_redir_valid", 64'(redir_valid), 64'h0);
    check("rst_redir_pc", 64'(redir_pc), 64'h0);
    check("rst_hard_intr", 64'(hard_intr), 64'h0);
    rst = 1'b0;
    step();

    // T1: overflow
    present(7'b0000100, 32'h8000_1000, 1'b0);
    step(); clear_in();
    check("t1_we", 64'(cp0w.we), 64'h1);
    check("t1_exc", 64'(cp0w.exc), 64'd12);
    check("t1_epc", 64'(cp0w.epc), 64'h8000_1000);
    check("t1_exl", 64'(cp0w.exl), 64'h1);
    check("t1_bva", 64'(cp0w.bva), 64'hCAFE_0000);
    check("t1_redir_valid", 64'(redir_valid), 64'h1);
    check("t1_redir_pc", 64'(redir_pc), 64'hBFC0_0380);
    check("t1_flush", 64'(flush), 64'h1);
    step();
    check("t1_we_pulse", 64'(cp0w.we), 64'h0);
    check("t1_redir_pulse", 64'(redir_valid), 64'h0);
    check("t1_flush_drain", 64'(flush), 64'h1);
    step();
    check("t1_flush_drain2", 64'(flush), 64'h1);
    step();
    check("t1_flush_end", 64'(flush), 64'h0);

    // T2: adel_d + ades in a delay slot -> AdEL with data address
    mem_badva = 32'h13;
    present(7'b1100000, 32'h8000_2004, 1'b1);
    step(); clear_in();
    check("t2_exc", 64'(cp0w.exc), 64'd4);
    check("t2_epc", 64'(cp0w.epc), 64'h8000_2000);
    check("t2_bva", 64'(cp0w.bva), 64'h13);
    check("t2_bd", 64'(cp0w.bd), 64'h1);
    drain();

    // T3: interrupt beats sys; second sys during DRAIN is ignored
    intr_vect = 8'h04;
    present(7'b0001000, 32'h8000_4000, 1'b0);
    step(); clear_in();
    check("t3_exc", 64'(cp0w.exc), 64'd0);
    check("t3_epc", 64'(cp0w.epc), 64'h8000_4000);
    step();
    present(7'b0001000, 32'h8000_4004, 1'b0);
    step();
    check("t3_drain_we", 64'(cp0w.we), 64'h0);
    check("t3_drain_redir", 64'(redir_valid), 64'h0);
    clear_in();
    step();
    check("t3_idle_we", 64'(cp0w.we), 64'h0);
    check("t3_idle_flush", 64'(flush), 64'h0);

    // T4: ERET, then ERET with bp
    er_epc = 32'h8000_3000; cur_bd = 1'b1; cur_exc = 5'd8;
    mem_eret = 1'b1;
    present(7'b0, 32'h8000_5000, 1'b0);
    step(); clear_in();
    check("t4_we", 64'(cp0w.we), 64'h1);
    check("t4_exl", 64'(cp0w.exl), 64'h0);
    check("t4_epc", 64'(cp0w.epc), 64'h8000_3000);
    check("t4_bd", 64'(cp0w.bd), 64'h1);
    check("t4_exc", 64'(cp0w.exc), 64'd8);
    check("t4_redir_pc", 64'(redir_pc), 64'h8000_3000);
    drain();
    mem_eret = 1'b1;
    present(7'b0010000, 32'h8000_6000, 1'b0);
    step(); clear_in();
    check("t4b_exc", 64'(cp0w.exc), 64'd9);
    check("t4b_exl", 64'(cp0w.exl), 64'h1);
    check("t4b_redir_pc", 64'(redir_pc), 64'hBFC0_0380);
    drain();

    // T5: stall blocks ri; reset during DRAIN
    stall = 1'b1;
    present(7'b0000010, 32'h8000_7000, 1'b0);
    step();
    check("t5_stall_we", 64'(cp0w.we), 64'h0);
    check("t5_stall_flush", 64'(flush), 64'h0);
    step();
    check("t5_stall_redir", 64'(redir_valid), 64'h0);
    stall = 1'b0;
    step(); clear_in();
    check("t5_we", 64'(cp0w.we), 64'h1);
    check("t5_exc", 64'(cp0w.exc), 64'd10);
    step();
    check("t5_in_drain", 64'(flush), 64'h1);
    rst = 1'b1;
    step();
    check("t5_rst_flush", 64'(flush), 64'h0);
    check("t5_rst_cp0w", 64'(cp0w), 64'h0);
    rst = 1'b0;
    step();

    // T6: synchroniser latency
    hw_int_raw = 6'b000100;
    step();
    check("t6_sync_1", 64'(hard_intr[2]), 64'h0);
    step();
    check("t6_sync_2", 64'(hard_intr[2]), 64'h1);
    hw_int_raw = 6'b0;
    step();
    check("t6_sync_hold", 64'(hard_intr[2]), 64'h1);
    step();
    check("t6_sync_clear", 64'(hard_intr[2]), 64'h0);

`ifdef EXC_TIMER_EN
    // Count reaches 10 at edge 20 after reset; pending shows after edge 21.
    rst = 1'b1;
    step();
    rst = 1'b0;
    tmr_we = 1'b1; tmr_cmp = 32'd10;
    step();
    tmr_we = 1'b0;
    first_hi = -1;
    for (int i = 2; i < 42; i++) begin
      step();
      if (first_hi < 0 && hard_intr[5]) first_hi = i;
    end
    check("t6_timer_rise", 64'(first_hi), 64'd21);
    tmr_we = 1'b1; tmr_cmp = 32'd1000;
    step();
    tmr_we = 1'b0;
    check("t6_timer_clear", 64'(hard_intr[5]), 64'h0);
`else
    first_hi = 0;
    tmr_we = 1'b1; tmr_cmp = 32'h0;
    step();
    tmr_we = 1'b0;
    check("t6_no_timer", 64'(hard_intr[5]), 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
